// File: rtl/forward_ctrl_pkg.sv
// forward_ctrl_pkg
// Purpose: constants shared by the forwarding unit and the downstream ALU
//          operand muxes. It holds the operand-select encodings and the
//          register-address width.
// Ports:   none (package)
package forward_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Operand-select encoding. 2'b11 is never produced.
  localparam logic [1:0] FWD_REG = 2'b00;  // register-file read data
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write-back data
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

endpackage : forward_ctrl_pkg

// File: rtl/forward_ctrl_sel.sv
// forward_sel
// Purpose: combinational operand-select for one ALU source. The EX/MEM
//          producer has priority over the MEM/WB producer because it holds
//          the most recent value. Register $0 is never forwarded.
// Ports:
//   src    in  [REG_ADDR_W-1:0]  source register of the EX instruction
//   mem_rd in  [REG_ADDR_W-1:0]  destination held in EX/MEM
//   mem_we in  1                 EX/MEM instruction writes the register file
//   wb_rd  in  [REG_ADDR_W-1:0]  destination held in MEM/WB
//   wb_we  in  1                 MEM/WB instruction writes the register file
//   sel    out [1:0]             operand-mux select
module forward_sel
  import forward_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_we,
  output logic [1:0]            sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_we && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = wb_we  && (wb_rd  != '0) && (wb_rd  == src);

  always_comb begin
    sel = FWD_REG;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule : forward_sel

// File: rtl/forward_ctrl.sv
// forward_ctrl
// Purpose: data-forwarding and load-use hazard unit for a 5-stage pipeline.
//          Tracks the destinations of the instructions in EX/MEM and MEM/WB,
//          drives the ALU operand-mux selects and raises a stall on a
//          load-use hazard. It also keeps a saturating count of stall cycles.
// Ports:
//   clk_i          in  1   clock, rising edge
//   rst_i          in  1   asynchronous reset, active low
//   ex_rs_i        in  5   rs of the EX instruction
//   ex_rt_i        in  5   rt of the EX instruction
//   ex_rd_i        in  5   destination of the EX instruction
//   ex_regwrite_i  in  1   EX instruction writes the register file
//   ex_memread_i   in  1   EX instruction is a load
//   id_rs_i        in  5   rs of the ID instruction
//   id_rt_i        in  5   rt of the ID instruction
//   flush_i        in  1   squash the EX instruction
//   fwd_a_o        out 2   operand-A mux select
//   fwd_b_o        out 2   operand-B mux select
//   stall_o        out 1   load-use stall
//   stall_cnt_o    out 16  saturating stall-cycle count
module forward_ctrl
  import forward_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_regwrite_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  stall_o,
  output logic [15:0]           stall_cnt_o
);

  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_we;

  // The tracking registers advance even while stalled. The bubble comes in
  // through ex_regwrite_i=0 on the following cycle. A squashed instruction
  // enters EX/MEM with its write enable cleared, so it never acts as a
  // forwarding source.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_rd <= '0;
      mem_we <= 1'b0;
      wb_rd  <= '0;
      wb_we  <= 1'b0;
    end else begin
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      mem_rd <= ex_rd_i;
      mem_we <= ex_regwrite_i & ~flush_i;
    end
  end

  forward_sel u_sel_a (
    .src    (ex_rs_i),
    .mem_rd (mem_rd),
    .mem_we (mem_we),
    .wb_rd  (wb_rd),
    .wb_we  (wb_we),
    .sel    (fwd_a_o)
  );

  forward_sel u_sel_b (
    .src    (ex_rt_i),
    .mem_rd (mem_rd),
    .mem_we (mem_we),
    .wb_rd  (wb_rd),
    .wb_we  (wb_we),
    .sel    (fwd_b_o)
  );

  // A flushed load cannot cause a stall because its result is discarded.
  assign stall_o = ex_memread_i & ex_regwrite_i & ~flush_i &
                   (ex_rd_i != '0) &
                   ((ex_rd_i == id_rs_i) | (ex_rd_i == id_rt_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule : forward_ctrl

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  input  1  asynchronous, active-low reset.
REQ-003 ex_rs_i  input  5  rs field of the instruction in EX.
REQ-004 ex_rt_i  input  5  rt field of the instruction in EX.
REQ-005 ex_rd_i  input  5  destination register of the instruction in EX (after RegDst select).
REQ-006 ex_regwrite_i  input  1  EX instruction writes the register file.
REQ-007 ex_memread_i  input  1  EX instruction is a load.
REQ-008 id_rs_i  input  5  rs field of the instruction in ID.
REQ-009 id_rt_i  input  5  rt field of the instruction in ID.
REQ-010 flush_i  input  1  squash the EX instruction (taken branch or jump).
REQ-011 fwd_a_o  output  2  select for the ALU operand-A 3-to-1 mux.
REQ-012 fwd_b_o  output  2  select for the ALU operand-B 3-to-1 mux.
REQ-013 stall_o  output  1  load-use hazard; PC and IF/ID hold, ID/EX loads a bubble.
REQ-014 stall_cnt_o  output  16  saturating count of stall cycles.

Function
REQ-015 Select encoding: 2'b00 = register-file data; 2'b01 = MEM/WB write-back data; 2'b10 = EX/MEM ALU result; 2'b11 is never driven.
REQ-016 Internal tracking registers: mem_rd(5), mem_we(1), wb_rd(5), wb_we(1), mirroring the EX/MEM and MEM/WB destination fields.
REQ-017 Each rising edge: wb_rd<=mem_rd, wb_we<=mem_we, mem_rd<=ex_rd_i, mem_we<=ex_regwrite_i & ~flush_i.
REQ-018 Tracking advances every cycle regardless of stall_o (the stall bubble arrives via ex_regwrite_i=0 next cycle).
REQ-019 fwd_a_o = 2'b10 when mem_we and mem_rd!=0 and mem_rd==ex_rs_i.
REQ-020 Otherwise fwd_a_o = 2'b01 when wb_we and wb_rd!=0 and wb_rd==ex_rs_i; otherwise 2'b00.
REQ-021 fwd_b_o follows the identical rule using ex_rt_i.
REQ-022 EX/MEM match SHALL take priority over MEM/WB match (the most recent producer wins).
REQ-023 Register $0 SHALL never be forwarded, regardless of write-enable.
REQ-024 fwd_a_o and fwd_b_o are combinational from inputs and tracking registers; zero-cycle latency.
REQ-025 stall_o = ex_memread_i & ex_regwrite_i & ~flush_i & (ex_rd_i!=0) & (ex_rd_i==id_rs_i | ex_rd_i==id_rt_i); combinational.
REQ-026 stall_cnt_o increments by 1 on each rising edge with stall_o=1 and holds at 16'hFFFF (no wrap).
REQ-027 flush_i and a load-use match in the same cycle: stall_o=0, and the squashed instruction never appears as a forwarding source.

Reset
REQ-028 rst_i low: mem_rd, wb_rd = 0; mem_we, wb_we = 0; stall_cnt_o = 0, immediately and independently of clk_i.
REQ-029 During and directly after reset: fwd_a_o = fwd_b_o = 2'b00; stall_o depends on inputs only.
REQ-030 Reset asserted mid-operation discards all in-flight tracking; the first post-reset cycle forwards nothing.

Structure
REQ-031 Shared package holds FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and REG_ADDR_W=5; the downstream mux and this block both use these constants.
REQ-032 One sub-module, forward_sel: combinational comparator taking (src, mem_rd, mem_we, wb_rd, wb_we) and returning a 2-bit select; instantiated twice, for A and B.
REQ-033 No other state beyond REQ-016 and the stall counter.

Verification
REQ-034 EX writes $8 (ex_rd_i=8, regwrite=1); next cycle ex_rs_i=8 -> fwd_a_o=2'b10; following cycle ex_rt_i=8 with no new writer -> fwd_b_o=2'b01.
REQ-035 Two consecutive writers of $9; third instruction reads rs=9 -> fwd_a_o=2'b10 (EX/MEM priority), not 2'b01.
REQ-036 Writer with rd=0, regwrite=1; next instruction rs=rt=0 -> fwd_a_o=fwd_b_o=2'b00.
REQ-037 Load (memread=1, rd=10) in EX, id_rt_i=10 -> stall_o=1 and stall_cnt_o goes 0->1; same with flush_i=1 -> stall_o=0, and the next-cycle reader of $10 gets 2'b00.
REQ-038 Force 65535 stall cycles, then 3 more -> stall_cnt_o holds 16'hFFFF.
REQ-039 Writer of $12 in flight, rst_i pulsed low between edges -> tracking clears asynchronously; reader of $12 afterwards gets 2'b00 and stall_cnt_o=0.
